// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor and its display path:
//   FSM state encoding, 7-segment glyph table (active-high, bit8 = dp,
//   bits6:0 = g..a) and a helper that splits a 0..99 value into decimal digits.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [8:0] SEG_BLANK = 9'h000;

    localparam logic [8:0] SEG_DIGIT [0:9] = '{
        9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
        9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f
    };

    // Returns {tens, ones}; callers keep v below 100 so each digit fits 4 bits.
    function automatic logic [7:0] split_decimal(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec
//   Decodes one decimal digit to a 7-segment pattern (dp always 0).
//   Codes 10..15 produce a blank digit.
// Ports:
//   digit  in   4   decimal digit code
//   seg    out  9   active-high pattern, bit8 = dp, bits6:0 = g..a
module seg7_dec
    import serial_sub_pkg::*;
(
    input  logic [3:0] digit,
    output logic [8:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                seg = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/serial_subtractor_4bit_disp.sv
// serial_subtractor_4bit_disp
//   Bit-serial subtractor: diff = a - b computed LSB-first, one bit per clock,
//   with a borrow flip-flop, a start/done handshake and a two-digit 7-segment
//   display of the result.
// Parameters:
//   WIDTH     operand width, legal 2..6 so the magnitude fits two decimal digits
// Configuration macro:
//   SUB_NEG_SIGN_EN  when defined, a negative result is shown as its magnitude
//                    with the tens dp lit; otherwise diff is shown as unsigned.
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      operation request, honoured in IDLE (and DONE, see FSM)
//   a, b      in   WIDTH  minuend / subtrahend, captured on the accepting edge
//   busy      out  1      high in SHIFT and DONE
//   done      out  1      one-cycle pulse, result valid from this cycle
//   diff      out  WIDTH  two's-complement difference, held until next done
//   borrow    out  1      final borrow (a < b), held until next done
//   seg_ones  out  9      ones digit pattern
//   seg_tens  out  9      tens digit pattern
//   led       out  8      active-low: led[0] = ~busy, led[1] = ~borrow, rest off
module serial_subtractor_4bit_disp
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [8:0]       seg_ones,
    output logic [8:0]       seg_tens,
    output logic [7:0]       led
);

    localparam int CNT_W = 3;
    localparam logic [8:0] SEG_ZERO = 9'h03f;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg, sr_reg, diff_reg;
    logic             brw_reg, borrow_reg, done_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [8:0]       seg_ones_reg, seg_tens_reg;

    logic             bit_d, brw_next, last_bit, load;
    logic [WIDTH-1:0] result_next;
    logic [6:0]       disp_value;
    logic             disp_dp;
    logic [7:0]       digits;
    logic [3:0]       digit_arr [2];
    logic [8:0]       pat_arr   [2];

    // Full-subtractor cell on the current LSBs.
    assign bit_d       = sa_reg[0] ^ sb_reg[0] ^ brw_reg;
    assign brw_next    = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & brw_reg);
    assign result_next = {bit_d, sr_reg[WIDTH-1:1]};
    assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));

    // FSM. A start seen in DONE is accepted directly, so with start held the
    // unit produces one result every WIDTH+1 cycles and busy never drops.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Display value is derived from the result being completed this cycle, so
    // the digit registers load together with diff/borrow.
`ifdef SUB_NEG_SIGN_EN
    assign disp_value = brw_next ? ((7'd1 << WIDTH) - 7'(result_next)) : 7'(result_next);
    assign disp_dp    = brw_next;
`else
    assign disp_value = 7'(result_next);
    assign disp_dp    = 1'b0;
`endif

    assign digits       = split_decimal(disp_value);
    assign digit_arr[0] = digits[3:0];
    assign digit_arr[1] = digits[7:4];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            seg7_dec u_dec (
                .digit (digit_arr[gi]),
                .seg   (pat_arr[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg       <= '0;
            sb_reg       <= '0;
            sr_reg       <= '0;
            brw_reg      <= 1'b0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            seg_ones_reg <= SEG_ZERO;
            seg_tens_reg <= SEG_ZERO;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                sa_reg  <= a;
                sb_reg  <= b;
                brw_reg <= 1'b0;
                cnt_reg <= '0;
            end else if (state_reg == ST_SHIFT) begin
                sa_reg  <= sa_reg >> 1;
                sb_reg  <= sb_reg >> 1;
                sr_reg  <= result_next;
                brw_reg <= brw_next;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_bit) begin
                    diff_reg     <= result_next;
                    borrow_reg   <= brw_next;
                    done_reg     <= 1'b1;
                    seg_ones_reg <= pat_arr[0];
                    seg_tens_reg <= pat_arr[1] | {disp_dp, 8'h00};
                end
            end
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign diff     = diff_reg;
    assign borrow   = borrow_reg;
    assign seg_ones = seg_ones_reg;
    assign seg_tens = seg_tens_reg;
    assign led      = {6'h3f, ~borrow_reg, ~busy};

endmodule

// File: tb/tb_serial_subtractor_4bit_disp.sv
// Testbench for serial_subtractor_4bit_disp (WIDTH=4): directed cases with
// literal expectations plus randomized traffic checked every cycle against a
// transaction-level model (arithmetic result, fixed latency, decimal display).
module tb_serial_subtractor_4bit_disp;

    localparam int WIDTH = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy, done, borrow;
    logic [WIDTH-1:0] diff;
    logic [8:0]       seg_ones, seg_tens;
    logic [7:0]       led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor_4bit_disp #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .seg_ones (seg_ones),
        .seg_tens (seg_tens),
        .led      (led)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [0:9] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                  7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

    // {tens pattern, ones pattern} for operands av, bv
    function automatic logic [17:0] disp_model(input int av, input int bv);
        int   v;
        logic dp;
`ifdef SUB_NEG_SIGN_EN
        if (av < bv) begin v = bv - av; dp = 1'b1; end
        else         begin v = av - bv; dp = 1'b0; end
`else
        v  = (av - bv + (1 << WIDTH)) % (1 << WIDTH);
        dp = 1'b0;
`endif
        return {dp, 1'b0, seg_tab[v / 10], 2'b00, seg_tab[v % 10]};
    endfunction

    int               m_rem    = 0;   // edges left until the pending result appears
    logic             m_done   = 1'b0;
    logic [WIDTH-1:0] m_a      = '0;
    logic [WIDTH-1:0] m_b      = '0;
    logic [WIDTH-1:0] m_diff   = '0;
    logic             m_borrow = 1'b0;
    logic [8:0]       m_ones   = 9'h03f;
    logic [8:0]       m_tens   = 9'h03f;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem    <= 0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_ones   <= 9'h03f;
            m_tens   <= 9'h03f;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_rem <= WIDTH;
                    m_a   <= a;
                    m_b   <= b;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_diff             <= m_a - m_b;
                    m_borrow           <= (m_a < m_b);
                    m_done             <= 1'b1;
                    {m_tens, m_ones}   <= disp_model(int'(m_a), int'(m_b));
                end
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("done",     {31'd0, done},   {31'd0, m_done});
            chk("busy",     {31'd0, busy},   {31'd0, (m_rem > 0) || m_done});
            chk("diff",     32'(diff),       32'(m_diff));
            chk("borrow",   {31'd0, borrow}, {31'd0, m_borrow});
            chk("seg_ones", 32'(seg_ones),   32'(m_ones));
            chk("seg_tens", 32'(seg_tens),   32'(m_tens));
            chk("led",      32'(led),        32'({6'h3f, ~m_borrow, ~((m_rem > 0) || m_done)}));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int lat;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 3 * WIDTH; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(WIDTH));
        $display("op a=%0d b=%0d -> diff=%0h borrow=%0b ones=%h tens=%h", av, bv, diff, borrow, seg_ones, seg_tens);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"},   {31'd0, done},   32'd0);
        chk({tag, "_busy"},   {31'd0, busy},   32'd0);
        chk({tag, "_diff"},   32'(diff),       32'd0);
        chk({tag, "_borrow"}, {31'd0, borrow}, 32'd0);
        chk({tag, "_ones"},   32'(seg_ones),   32'h03f);
        chk({tag, "_tens"},   32'(seg_tens),   32'h03f);
        chk({tag, "_led"},    32'(led),        32'hff);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, nlow, got;

        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // 1. 9 - 3
        run_op(4'd9, 4'd3);
        chk("t1_diff",   32'(diff),       32'd6);
        chk("t1_borrow", {31'd0, borrow}, 32'd0);
        chk("t1_ones",   32'(seg_ones),   32'h07d);
        chk("t1_tens",   32'(seg_tens),   32'h03f);
        @(negedge clk);
        chk("t1_pulse", {31'd0, done}, 32'd0);

        // 2. 3 - 9 wraps
        run_op(4'd3, 4'd9);
        chk("t2_diff",   32'(diff),       32'h0a);
        chk("t2_borrow", {31'd0, borrow}, 32'd1);
        chk("t2_led1",   {31'd0, led[1]}, 32'd0);
`ifdef SUB_NEG_SIGN_EN
        chk("t2_ones", 32'(seg_ones), 32'h07d);
        chk("t2_tens", 32'(seg_tens), 32'h13f);
`else
        chk("t2_ones", 32'(seg_ones), 32'h03f);
        chk("t2_tens", 32'(seg_tens), 32'h006);
`endif

        // 3. extremes
        run_op(4'd15, 4'd0);
        chk("t3_diff", 32'(diff),     32'd15);
        chk("t3_ones", 32'(seg_ones), 32'h06d);
        chk("t3_tens", 32'(seg_tens), 32'h006);
        run_op(4'd5, 4'd5);
        chk("t3_eq_diff",   32'(diff),       32'd0);
        chk("t3_eq_borrow", {31'd0, borrow}, 32'd0);
        chk("t3_eq_ones",   32'(seg_ones),   32'h03f);
        chk("t3_eq_tens",   32'(seg_tens),   32'h03f);
        wait_idle();

        // 4. start during SHIFT is ignored
        @(negedge clk); start = 1'b1; a = 4'd12; b = 4'd5;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk); start = 1'b0;
        nd = 0; got = -1;
        for (int k = 0; k < 3 * WIDTH; k++) begin
            @(negedge clk);
            if (done) begin nd++; got = int'(diff); end
        end
        chk("t4_dones", 32'(nd),  32'd1);
        chk("t4_diff",  32'(got), 32'd7);

        // 5. reset during SHIFT
        @(negedge clk); start = 1'b1; a = 4'd10; b = 4'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t5");
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("t5_no_done", 32'(nd), 32'd0);
        run_op(4'd8, 4'd1);
        chk("t5_after_diff", 32'(diff), 32'd7);

        // 6. start held high: back-to-back operations
        @(negedge clk); start = 1'b1; a = 4'd7; b = 4'd2;
        nd = 0; nlow = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("t6_diff", 32'(diff), 32'd5);
            end
            if (!busy) nlow++;
        end
        start = 1'b0;
        chk("t6_dones",    32'(nd),   32'd3);
        chk("t6_busy_low", 32'(nlow), 32'd0);
        wait_idle();

        // Randomized traffic, including occasional asynchronous resets.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            if ($urandom_range(0, 96) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            if (done) $display("rand done diff=%0h borrow=%0b ones=%h tens=%h", diff, borrow, seg_ones, seg_tens);
        end
        start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
